// File: rtl/pong_pkg.sv
// Shared constants for the pong design: display size, paddle motion codes and FSM states.
package pong_pkg;

  localparam int unsigned D_WIDTH  = 640;
  localparam int unsigned D_HEIGHT = 480;

  localparam logic [1:0] DIR_RIGHT = 2'd0;
  localparam logic [1:0] DIR_LEFT  = 2'd1;
  localparam logic [1:0] DIR_STOP  = 2'd2;

  typedef enum logic [1:0] {
    StStop  = 2'd0,
    StMoveL = 2'd1,
    StMoveR = 2'd2
  } paddle_state_t;

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser followed by a stability counter; the accepted level only
// changes after the synced input has differed from it for DB_CYCLES consecutive clocks.
module btn_debounce #(
  parameter int unsigned DB_CYCLES = 50000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_raw,
  output logic o_level
);

  localparam int unsigned CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic          sync1_q;
  logic          sync2_q;
  logic [CW-1:0] cnt_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
      o_level <= 1'b0;
    end else begin
      sync1_q <= i_raw;
      sync2_q <= sync1_q;
      if (sync2_q == o_level) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        o_level <= ~o_level;
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/paddle_ctrl.sv
// Paddle controller: debounced left/right buttons drive a clamped left-edge position
// that steps on animation strobes and speeds up after a sustained run in one direction.
module paddle_ctrl import pong_pkg::*; #(
  parameter int unsigned P_WIDTH    = 100,
  parameter int unsigned IX         = 270,
  parameter int unsigned D_WIDTH    = pong_pkg::D_WIDTH,
  parameter int unsigned DB_CYCLES  = 50000,
  parameter int unsigned FAST_AFTER = 30,
  parameter int unsigned FAST_STEP  = 3
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_ani_stb,
  input  logic        i_animate,
  input  logic        i_btn_l,
  input  logic        i_btn_r,
  input  logic        i_recentre,
  output logic [11:0] o_x,
  output logic [1:0]  o_dir
);

  localparam int unsigned XMAX = D_WIDTH - P_WIDTH;
  localparam int unsigned RW   = $clog2(FAST_AFTER + 1);

  localparam logic [11:0]   IX12        = 12'(IX);
  localparam logic [11:0]   XMAX12      = 12'(XMAX);
  localparam logic [12:0]   XMAX13      = 13'(XMAX);
  localparam logic [11:0]   FAST_STEP12 = 12'(FAST_STEP);
  localparam logic [RW-1:0] FAST_AFTER_R = RW'(FAST_AFTER);

  logic          lvl_l;
  logic          lvl_r;
  paddle_state_t req;
  paddle_state_t state_q;
  logic [RW-1:0] run_q;
  logic [RW-1:0] run_inc;
  logic [RW-1:0] run_nxt;
  logic          same;
  logic [11:0]   step;
  logic [12:0]   x_sum;
  logic [11:0]   x_right;
  logic [11:0]   x_left;
  logic [11:0]   x_tgt;
  logic          moved;

  btn_debounce #(
    .DB_CYCLES(DB_CYCLES)
  ) u_db_l (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_raw  (i_btn_l),
    .o_level(lvl_l)
  );

  btn_debounce #(
    .DB_CYCLES(DB_CYCLES)
  ) u_db_r (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_raw  (i_btn_r),
    .o_level(lvl_r)
  );

  always_comb begin
    req = StStop;
    if (lvl_l && !lvl_r) begin
      req = StMoveL;
    end else if (lvl_r && !lvl_l) begin
      req = StMoveR;
    end
  end

  // Speed is judged on the run length including the current strobe.
  always_comb begin
    same    = (req == state_q);
    run_inc = (&run_q) ? run_q : run_q + 1'b1;
    run_nxt = same ? run_inc : '0;
    step    = (same && (run_inc >= FAST_AFTER_R)) ? FAST_STEP12 : 12'd1;
    x_sum   = {1'b0, o_x} + {1'b0, step};
    x_right = (x_sum > XMAX13) ? XMAX12 : x_sum[11:0];
    x_left  = (o_x > step) ? (o_x - step) : 12'd0;
    x_tgt   = (req == StMoveR) ? x_right : x_left;
    moved   = (req != StStop) && (x_tgt != o_x);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= StStop;
      run_q   <= '0;
      o_x     <= IX12;
      o_dir   <= DIR_STOP;
    end else if (i_recentre) begin
      state_q <= StStop;
      run_q   <= '0;
      o_x     <= IX12;
      o_dir   <= DIR_STOP;
    end else if (i_ani_stb) begin
      if (i_animate && moved) begin
        state_q <= req;
        run_q   <= run_nxt;
        o_x     <= x_tgt;
        o_dir   <= (req == StMoveR) ? DIR_RIGHT : DIR_LEFT;
      end else begin
        // Covers animation off, no/both buttons, and pushing against a wall.
        state_q <= StStop;
        run_q   <= '0;
        o_dir   <= DIR_STOP;
      end
    end
  end

endmodule
